subleq_mem_responder: RTL and testbench

//  Memory-side responder for the 8-bit subleq core: a 256x8 RAM that serves the core's read port (registered,
//  1-cycle latency) and write port. It also provides a byte-stream program loader that holds the core in reset,
//  and a memory-mapped output FIFO. It sits between the core and the host/audio-side byte streams.

---
 rtl/subleq_mem_responder.sv | 114 +++++++++++
 tb/tb_subleq_mem_responder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/subleq_mem_responder.sv
// subleq_mem_responder: 256x8 RAM, program loader and output FIFO for the subleq core. Optional halt: SUBLEQ_MEM_HALT_EN
module subleq_mem_responder #(
  parameter int         LOAD_BYTES = 256,
  parameter logic [7:0] OUT_ADDR   = 8'hFF,
  parameter int         OUT_DEPTH  = 4,
  parameter logic [7:0] HALT_ADDR  = 8'hFE
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_raddr,
  output logic [7:0] o_rdata,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic       i_we,
  output logic       o_cpu_rstn,
  input  logic       i_load_start,
  input  logic       i_load_valid,
  input  logic [7:0] i_load_data,
  output logic       o_load_ready,
  output logic       o_load_done,
  output logic       o_out_valid,
  output logic [7:0] o_out_data,
  input  logic       i_out_ready,
  output logic       o_out_overflow,
  output logic       o_halted
);
`ifdef SUBLEQ_MEM_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif
  localparam int PW = $clog2(OUT_DEPTH);
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;
  state_t          r_state;
  logic [7:0]      r_ptr;
  logic            r_cpu_rstn;
  logic [7:0]      r_mem [256];
  logic [7:0]      r_fifo [OUT_DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [PW:0]     r_cnt;
  logic            r_ovf;
  logic            w_load_acc, w_core_we, w_mem_we, w_last, w_halt_hit;
  logic            w_push, w_pop, w_full, w_push_ok, w_flush;
  logic [7:0]      w_laddr, w_mem_addr, w_mem_data;
  // A load_start in LOAD restarts at address 0, even for a byte arriving in the same cycle
  assign w_load_acc = (r_state == S_LOAD) & i_load_valid;
  assign w_laddr    = i_load_start ? 8'd0 : r_ptr;
  assign w_core_we  = (r_state == S_RUN) & i_we;
  assign w_mem_we   = w_load_acc | w_core_we;
  assign w_mem_addr = w_load_acc ? w_laddr : i_waddr;
  assign w_mem_data = w_load_acc ? i_load_data : i_wdata;
  assign w_last     = w_load_acc & ({1'b0, w_laddr} == 9'(LOAD_BYTES - 1));
  assign w_halt_hit = HALT_EN & w_core_we & (i_waddr == HALT_ADDR) & ~i_load_start;
  assign w_flush    = (r_state != S_LOAD) & i_load_start;
  assign w_push     = w_core_we & (i_waddr == OUT_ADDR);
  assign w_pop      = o_out_valid & i_out_ready;
  assign w_full     = r_cnt == (PW + 1)'(OUT_DEPTH);
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign o_cpu_rstn     = r_cpu_rstn;
  assign o_load_ready   = r_state == S_LOAD;
  assign o_load_done    = r_state != S_LOAD;
  assign o_halted       = r_state == S_HALT;
  assign o_out_valid    = r_cnt != '0;
  assign o_out_data     = o_out_valid ? r_fifo[r_rp] : 8'd0;
  assign o_out_overflow = r_ovf;
  // RAM and FIFO storage, no reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    if (w_push_ok) r_fifo[r_wp] <= i_wdata;
  end
  // Registered read-first port
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) o_rdata <= 8'd0;
    else         o_rdata <= r_mem[i_raddr];
  end
  // Load/run/halt sequencing; core reset release lags RUN entry by one cycle
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= S_LOAD;
      r_ptr      <= 8'd0;
      r_cpu_rstn <= 1'b0;
    end else begin
      r_cpu_rstn <= (r_state == S_RUN) & ~i_load_start & ~w_halt_hit;
      if (r_state == S_LOAD) begin
        if (w_last) r_state <= S_RUN;
        r_ptr <= w_load_acc ? w_laddr + 8'd1 : w_laddr;
      end else if (i_load_start) begin
        r_state <= S_LOAD;
        r_ptr   <= 8'd0;
      end else if (w_halt_hit) begin
        r_state <= S_HALT;
      end
    end
  end
  // Output FIFO bookkeeping; a full FIFO still accepts a push when it pops in the same cycle
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{PW{1'b0}}, w_push_ok} - {{PW{1'b0}}, w_pop};
      if (w_push & ~w_push_ok) r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_subleq_mem_responder.sv
// tb_subleq_mem_responder: directed checks of loader, RAM port, output FIFO and halt for subleq_mem_responder
module tb_subleq_mem_responder;
  logic       i_clk = 1'b0, i_rstn = 1'b0;
  logic [7:0] i_raddr = '0, i_waddr = '0, i_wdata = '0, i_load_data = '0;
  logic       i_we = 1'b0, i_load_start = 1'b0, i_load_valid = 1'b0, i_out_ready = 1'b0;
  logic [7:0] o_rdata, o_out_data;
  logic       o_cpu_rstn, o_load_ready, o_load_done, o_out_valid, o_out_overflow, o_halted;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] exp4 [4] = '{8'd2, 8'd3, 8'd4, 8'd9};

  subleq_mem_responder dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_raddr(i_raddr), .o_rdata(o_rdata),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_we(i_we), .o_cpu_rstn(o_cpu_rstn),
    .i_load_start(i_load_start), .i_load_valid(i_load_valid), .i_load_data(i_load_data),
    .o_load_ready(o_load_ready), .o_load_done(o_load_done), .o_out_valid(o_out_valid),
    .o_out_data(o_out_data), .i_out_ready(i_out_ready), .o_out_overflow(o_out_overflow),
    .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic core_wr(input logic [7:0] a, input logic [7:0] d);
    i_we = 1'b1; i_waddr = a; i_wdata = d;
    tick();
    i_we = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_rdata", o_rdata, 0);
    chk("rst_cpu_rstn", o_cpu_rstn, 0);
    chk("rst_load_ready", o_load_ready, 1);
    chk("rst_load_done", o_load_done, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_overflow", o_out_overflow, 0);
    chk("rst_halted", o_halted, 0);
    tick();
    i_rstn = 1'b1;
    tick();
    // partial load, then restart with a byte in the same cycle
    i_load_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      i_load_data = 8'(i);
      tick();
    end
    i_load_start = 1'b1; i_load_data = 8'hC3;
    tick();
    i_load_start = 1'b0;
    for (int i = 1; i < 255; i++) begin
      i_load_data = 8'(i);
      tick();
    end
    chk("done_before_last", o_load_done, 0);
    i_load_data = 8'hFF;
    tick();
    i_load_valid = 1'b0;
    chk("done_after_last", o_load_done, 1);
    chk("ready_after_last", o_load_ready, 0);
    chk("cpu_rstn_entry", o_cpu_rstn, 0);
    tick();
    chk("cpu_rstn_rise", o_cpu_rstn, 1);
    i_raddr = 8'h10; tick();
    chk("rd_10", o_rdata, 8'h10);
    i_raddr = 8'hFF; tick();
    chk("rd_ff", o_rdata, 8'hFF);
    i_raddr = 8'h00; tick();
    chk("rd_00_restart", o_rdata, 8'hC3);
    i_raddr = 8'h01; tick();
    chk("rd_01", o_rdata, 8'h01);
    // core writes and read-first collision
    core_wr(8'h20, 8'hA5);
    i_raddr = 8'h20; tick();
    chk("rd_20", o_rdata, 8'hA5);
    i_raddr = 8'h21;
    core_wr(8'h21, 8'h5A);
    chk("rd_21_old", o_rdata, 8'h21);
    tick();
    chk("rd_21_new", o_rdata, 8'h5A);
    // full FIFO, push and pop together
    i_out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) core_wr(8'hFF, 8'(v));
    chk("full_valid", o_out_valid, 1);
    chk("full_head", o_out_data, 1);
    i_out_ready = 1'b1;
    core_wr(8'hFF, 8'h09);
    chk("pushpop_no_ovf", o_out_overflow, 0);
    for (int k = 0; k < 4; k++) begin
      chk("pushpop_order", o_out_data, exp4[k]);
      tick();
    end
    chk("pushpop_empty", o_out_valid, 0);
    chk("pushpop_empty_data", o_out_data, 0);
    // overflow
    i_out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) core_wr(8'hFF, 8'(v));
    chk("ovf_set", o_out_overflow, 1);
    i_raddr = 8'hFF; tick();
    chk("rd_ff_last_push", o_rdata, 8'h05);
    i_out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain", o_out_data, k);
      tick();
    end
    chk("ovf_empty", o_out_valid, 0);
    chk("ovf_sticky", o_out_overflow, 1);
    i_out_ready = 1'b0;
    core_wr(8'hFF, 8'h77);
    // halt address write
    core_wr(8'hFE, 8'h01);
    i_raddr = 8'hFE; tick();
    chk("rd_fe", o_rdata, 8'h01);
`ifdef SUBLEQ_MEM_HALT_EN
    chk("halted", o_halted, 1);
    chk("halt_cpu_rstn", o_cpu_rstn, 0);
    chk("halt_load_ready", o_load_ready, 0);
    chk("halt_load_done", o_load_done, 1);
    core_wr(8'hFF, 8'h88);
`else
    chk("not_halted", o_halted, 0);
    chk("run_cpu_rstn", o_cpu_rstn, 1);
`endif
    chk("fifo_kept_valid", o_out_valid, 1);
    chk("fifo_kept_data", o_out_data, 8'h77);
    // reload from RUN/HALT
    i_load_start = 1'b1; tick();
    i_load_start = 1'b0;
    chk("reload_cpu_rstn", o_cpu_rstn, 0);
    chk("reload_flush", o_out_valid, 0);
    chk("reload_ovf_clr", o_out_overflow, 0);
    chk("reload_ready", o_load_ready, 1);
    chk("reload_done", o_load_done, 0);
    chk("reload_halted", o_halted, 0);
    core_wr(8'h30, 8'hEE);
    i_raddr = 8'h30; tick();
    chk("load_ignores_core_we", o_rdata, 8'h30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
